binary_division_sevenbit_by_fourbit: RTL and testbench

//  Sequential restoring divider, the inverse of the 3x4-bit product path.

---
 rtl/binary_division_sevenbit_by_fourbit.sv | 102 ++++++++++
 tb/tb_binary_division_sevenbit_by_fourbit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/binary_division_sevenbit_by_fourbit.sv
// rtl/binary_division_sevenbit_by_fourbit.sv - sequential restoring divider, one quotient bit per clock
module binary_division_sevenbit_by_fourbit #(
    parameter int DIVIDEND_W = 7,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] dvd_q;
    logic [DIVISOR_W-1:0]  dvs_q;

    logic [DIVISOR_W:0]    partial;
    logic [DIVISOR_W:0]    diff;
    logic                  fits;
    logic [DIVISOR_W-1:0]  rem_next;

    // Shift the next dividend bit into the running remainder and trial-subtract.
    always_comb begin
        partial  = {remainder, dvd_q[cnt]};
        diff     = partial - {1'b0, dvs_q};
        fits     = (partial >= {1'b0, dvs_q});
        rem_next = fits ? diff[DIVISOR_W-1:0] : partial[DIVISOR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dvd_q     <= dividend;
                        dvs_q     <= divisor;
                        remainder <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            div_by_zero <= 1'b1;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            state       <= RUN;
                            quotient    <= '0;
                            div_by_zero <= 1'b0;
                            cnt         <= CNT_W'(DIVIDEND_W - 1);
                            busy        <= 1'b1;
                            done        <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    remainder     <= rem_next;
                    quotient[cnt] <= fits;
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_division_sevenbit_by_fourbit.sv
// tb/tb_binary_division_sevenbit_by_fourbit.sv - self-checking bench for the sequential divider
module tb_binary_division_sevenbit_by_fourbit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [6:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    binary_division_sevenbit_by_fourbit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timing model: a division accepted at edge a is busy for edges a..a+6 and
    // shows done after edge a+7 with q = a/b, r = a%b; divide-by-zero finishes at once.
    int edge_n = 0;
    int run_end = -1;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_dz = 1'b0;
    int m_q = 0, m_r = 0, p_q = 0, p_r = 0;

    always @(posedge clk) begin
        edge_n++;
        m_done = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_dz = 1'b0; m_q = 0; m_r = 0; run_end = -1;
        end else if (m_busy) begin
            if (edge_n == run_end) begin
                m_busy = 1'b0; m_done = 1'b1; m_q = p_q; m_r = p_r;
            end
        end else if (start) begin
            if (divisor == 4'd0) begin
                m_q = 127; m_r = 0; m_dz = 1'b1; m_done = 1'b1;
            end else begin
                m_busy = 1'b1; m_dz = 1'b0; run_end = edge_n + 7;
                p_q = int'(dividend) / int'(divisor);
                p_r = int'(dividend) % int'(divisor);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", int'(busy), int'(m_busy));
            chk("model_done", int'(done), int'(m_done));
            if (!m_busy) begin
                chk("model_quotient", int'(quotient), m_q);
                chk("model_remainder", int'(remainder), m_r);
                chk("model_div_by_zero", int'(div_by_zero), int'(m_dz));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input int dvd, input int dvs, input int eq, input int er,
                          input int edz, input int elat);
        int lat;
        tick();
        dividend = 7'(dvd);
        divisor  = 4'(dvs);
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        chk("op_latency", lat, elat);
        chk("op_quotient", int'(quotient), eq);
        chk("op_remainder", int'(remainder), er);
        chk("op_div_by_zero", int'(div_by_zero), edz);
    endtask

    initial begin
        int lat, bc, dn, sq, sr;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) tick();
        chk_en = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_div_by_zero", int'(div_by_zero), 0);
        rst_n = 1'b1;
        tick();

        // T1..T3
        run_op(105, 7, 15, 0, 0, 7);
        run_op(127, 15, 8, 7, 0, 7);
        run_op(5, 9, 0, 5, 0, 7);
        run_op(0, 1, 0, 0, 0, 7);
        run_op(42, 0, 127, 0, 1, 0);
        run_op(42, 6, 7, 0, 0, 7);

        // T4: start pulse with other operands in the middle of a run is ignored
        tick();
        dividend = 7'd100; divisor = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        bc = int'(busy); dn = 0; sq = -1; sr = -1;
        for (int k = 1; k < 12; k++) begin
            tick();
            if (k == 2) begin start = 1'b1; dividend = 7'd9; divisor = 4'd2; end
            if (k == 3) start = 1'b0;
            bc += int'(busy);
            if (done) begin dn++; sq = int'(quotient); sr = int'(remainder); end
        end
        chk("t4_busy_cycles", bc, 7);
        chk("t4_done_pulses", dn, 1);
        chk("t4_quotient", sq, 33);
        chk("t4_remainder", sr, 1);

        // T5: reset in the middle of a run
        dividend = 7'd100; divisor = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_quotient", int'(quotient), 0);
        chk("t5_remainder", int'(remainder), 0);
        chk("t5_div_by_zero", int'(div_by_zero), 0);
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            dn += int'(done);
        end
        chk("t5_no_done", dn, 0);
        run_op(100, 3, 33, 1, 0, 7);

        // T6: exhaustive sweep with start held high through every done cycle
        tick();
        for (int i = 0; i < 2048; i++) begin
            int dvd, dvs;
            dvd = i >> 4;
            dvs = i & 15;
            dividend = 7'(dvd);
            divisor  = 4'(dvs);
            start    = 1'b1;
            wait_done_from_edge(lat);
            chk("t6_cost", lat, (dvs == 0) ? 1 : 8);
            if (dvs != 0) begin
                chk("t6_identity", int'(quotient) * dvs + int'(remainder), dvd);
                chk("t6_rem_lt_div", int'(remainder < 4'(dvs)), 1);
                chk("t6_div_by_zero", int'(div_by_zero), 0);
            end else begin
                chk("t6_dz_quotient", int'(quotient), 127);
                chk("t6_dz_remainder", int'(remainder), 0);
                chk("t6_dz_flag", int'(div_by_zero), 1);
            end
        end
        start = 1'b0;
        repeat (3) tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic wait_done_from_edge(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 20);
        if (!done) chk("sweep_timeout", 0, 1);
    endtask

endmodule
